// File: rtl/trans_stage_pkg.sv
// Shared definitions for the generic inter-stage pipeline register and the
// per-stage payload layouts packed into it.
package trans_stage_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned OCC_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_ONE   = 2'd1,
        STAGE_TWO   = 2'd2
    } stage_state_t;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned CAT_W   = 3;
    localparam int unsigned REG_W   = 5;

    localparam logic [OP_W-1:0]    OP_NOP    = OP_W'(0);
    localparam logic [CAT_W-1:0]   CAT_NONE  = CAT_W'(0);
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    // Per-stage payload layouts; field offsets follow from packed ordering (MSB first).
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [CAT_W-1:0] cat;
        logic [XLEN-1:0]  opa;
        logic [XLEN-1:0]  opb;
        logic             we;
        logic [REG_W-1:0] waddr;
    } id_ex_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [CAT_W-1:0] cat;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  store_data;
        logic             we;
        logic [REG_W-1:0] waddr;
    } ex_mem_t;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] waddr;
        logic [XLEN-1:0]  wdata;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    localparam if_id_t  IF_ID_NOP  = '{instr: INSTR_NOP};
    localparam id_ex_t  ID_EX_NOP  = '{op: OP_NOP, cat: CAT_NONE, opa: '0, opb: '0, we: 1'b0, waddr: '0};
    localparam ex_mem_t EX_MEM_NOP = '{op: OP_NOP, cat: CAT_NONE, result: '0, store_data: '0, we: 1'b0, waddr: '0};
    localparam mem_wb_t MEM_WB_NOP = '{we: 1'b0, waddr: '0, wdata: '0};

    function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
        case (s)
            STAGE_ONE: occ_of = OCC_W'(1);
            STAGE_TWO: occ_of = OCC_W'(2);
            default:   occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/trans_stage_skid.sv
// Two-entry skid buffer: main register M feeds the output, S absorbs one beat
// while downstream stalls so in_ready never depends on out_ready.
module trans_stage_skid
    import trans_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    stage_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic                  push, pop;

    // Ready is a decode of the state register; reset and flush only gate it off.
    assign in_ready  = ~reset & ~flush & (state_q != STAGE_TWO);
    assign out_valid = (state_q != STAGE_EMPTY);
    assign out_data  = m_q;
    assign occupancy = occ_of(state_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STAGE_EMPTY;
            m_q     <= NOP_VALUE;
            s_q     <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    // M is rewritten with NOP_VALUE whenever the stage empties, keeping out_data registered.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        push    = in_valid & in_ready;
        pop     = out_valid & out_ready;
        if (flush) begin
            state_d = STAGE_EMPTY;
            m_d     = NOP_VALUE;
        end else begin
            case (state_q)
                STAGE_EMPTY: begin
                    if (push) begin
                        m_d     = in_data;
                        state_d = STAGE_ONE;
                    end
                end
                STAGE_ONE: begin
                    if (push && pop) begin
                        m_d = in_data;
                    end else if (push) begin
                        s_d     = in_data;
                        state_d = STAGE_TWO;
                    end else if (pop) begin
                        m_d     = NOP_VALUE;
                        state_d = STAGE_EMPTY;
                    end
                end
                STAGE_TWO: begin
                    if (pop) begin
                        m_d     = s_q;
                        state_d = STAGE_ONE;
                    end
                end
                default: begin
                    m_d     = NOP_VALUE;
                    state_d = STAGE_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/trans_stage.sv
// Generic valid/ready pipeline register between two stages, with flush and a
// NOP bubble value; SKID selects the skid buffer or a single register.
module trans_stage
    import trans_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SKID       = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    if (SKID != 0) begin : g_skid
        trans_stage_skid #(
            .DATA_WIDTH (DATA_WIDTH),
            .NOP_VALUE  (NOP_VALUE)
        ) u_skid (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .occupancy (occupancy)
        );
    end else begin : g_single
        stage_state_t          state_q, state_d;
        logic [DATA_WIDTH-1:0] m_q, m_d;
        logic                  push, pop;

        // Combinational ready: a held entry leaving this cycle frees the slot.
        assign in_ready  = ~flush & ((state_q == STAGE_EMPTY) | out_ready);
        assign out_valid = (state_q != STAGE_EMPTY);
        assign out_data  = m_q;
        assign occupancy = occ_of(state_q);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= STAGE_EMPTY;
                m_q     <= NOP_VALUE;
            end else begin
                state_q <= state_d;
                m_q     <= m_d;
            end
        end

        always_comb begin
            state_d = state_q;
            m_d     = m_q;
            push    = in_valid & in_ready;
            pop     = out_valid & out_ready;
            if (flush) begin
                state_d = STAGE_EMPTY;
                m_d     = NOP_VALUE;
            end else if (push) begin
                m_d     = in_data;
                state_d = STAGE_ONE;
            end else if (pop) begin
                m_d     = NOP_VALUE;
                state_d = STAGE_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_trans_stage.sv
// Directed bench for trans_stage: skid variant, single-register variant and a
// non-zero NOP_VALUE instance driven from one linear sequence.
module tb_trans_stage;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // a_: SKID=1, b_: SKID=0, n_: SKID=1 with NOP_VALUE=DEADBEEF
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [1:0]  n_occ;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    trans_stage #(.DATA_WIDTH(32), .SKID(1)) dut_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    trans_stage #(.DATA_WIDTH(32), .SKID(0)) dut_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    trans_stage #(.DATA_WIDTH(32), .SKID(1), .NOP_VALUE(32'hDEAD_BEEF)) dut_n (
        .clock(clock), .reset(reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 0;

        cycle();
        check("rst_a_in_ready",  32'(a_in_ready), 32'h0);
        check("rst_a_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_a_out_data",  a_out_data, 32'h0);
        check("rst_a_occ",       32'(a_occ), 32'h0);
        cycle();
        reset = 1'b0;
        #1;
        check("rel_a_in_ready",  32'(a_in_ready), 32'h1);
        check("idle_n_out_data", n_out_data, 32'hDEAD_BEEF);
        check("idle_n_valid",    32'(n_out_valid), 32'h0);

        // streaming with out_ready held high
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h11;
        cycle();
        check("str_data_11", a_out_data, 32'h11);
        check("str_valid",   32'(a_out_valid), 32'h1);
        check("str_occ1",    32'(a_occ), 32'h1);
        check("str_ready1",  32'(a_in_ready), 32'h1);
        a_in_data = 32'h22;
        cycle();
        check("str_data_22", a_out_data, 32'h22);
        check("str_occ2",    32'(a_occ), 32'h1);
        a_in_data = 32'h33;
        cycle();
        check("str_data_33", a_out_data, 32'h33);
        check("str_ready3",  32'(a_in_ready), 32'h1);
        a_in_valid = 0;
        cycle();
        check("str_drain_valid", 32'(a_out_valid), 32'h0);
        check("str_drain_nop",   a_out_data, 32'h0);

        // backpressure fills the skid entry
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hA1;
        cycle();
        a_in_data = 32'hA2;
        cycle();
        check("bp_occ2",   32'(a_occ), 32'h2);
        check("bp_ready0", 32'(a_in_ready), 32'h0);
        check("bp_data",   a_out_data, 32'hA1);
        a_in_valid = 0; a_out_ready = 1;
        cycle();
        check("bp_data_a2", a_out_data, 32'hA2);
        check("bp_occ1",    32'(a_occ), 32'h1);
        cycle();
        check("bp_empty_valid", 32'(a_out_valid), 32'h0);
        check("bp_empty_nop",   a_out_data, 32'h0);
        check("bp_empty_occ",   32'(a_occ), 32'h0);

        // flush while full with a colliding input
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hB1;
        cycle();
        a_in_data = 32'hB2;
        cycle();
        a_in_data = 32'hB3; a_flush = 1;
        #1;
        check("fl2_ready0", 32'(a_in_ready), 32'h0);
        cycle();
        a_flush = 0; a_in_valid = 0;
        check("fl2_valid", 32'(a_out_valid), 32'h0);
        check("fl2_nop",   a_out_data, 32'h0);
        check("fl2_occ",   32'(a_occ), 32'h0);
        cycle();
        check("fl2_no_b3", 32'(a_out_valid), 32'h0);

        // flush in ONE must also block an otherwise-accepted input
        a_in_valid = 1; a_in_data = 32'hC1;
        cycle();
        a_in_data = 32'hC2; a_flush = 1;
        #1;
        check("fl1_ready0", 32'(a_in_ready), 32'h0);
        cycle();
        a_flush = 0; a_in_valid = 0;
        check("fl1_valid", 32'(a_out_valid), 32'h0);
        check("fl1_occ",   32'(a_occ), 32'h0);

        // single-register variant: combinational ready
        b_in_valid = 1; b_in_data = 32'hE1; b_out_ready = 0;
        cycle();
        b_in_valid = 0;
        check("s0_data_e1", b_out_data, 32'hE1);
        check("s0_occ1",    32'(b_occ), 32'h1);
        #1;
        check("s0_ready_lo", 32'(b_in_ready), 32'h0);
        b_out_ready = 1;
        #1;
        check("s0_ready_hi", 32'(b_in_ready), 32'h1);
        b_out_ready = 0;
        #1;
        check("s0_ready_lo2", 32'(b_in_ready), 32'h0);
        b_out_ready = 1; b_in_valid = 1; b_in_data = 32'hE2;
        cycle();
        check("s0_replace_e2", b_out_data, 32'hE2);
        check("s0_valid",      32'(b_out_valid), 32'h1);
        b_in_data = 32'hE3;
        cycle();
        check("s0_replace_e3", b_out_data, 32'hE3);
        b_in_valid = 0;
        cycle();
        check("s0_drain_nop", b_out_data, 32'h0);
        check("s0_drain_occ", 32'(b_occ), 32'h0);

        // custom NOP value returns after a payload drains
        n_out_ready = 1; n_in_valid = 1; n_in_data = 32'hF1;
        cycle();
        n_in_valid = 0;
        check("nop_data_f1", n_out_data, 32'hF1);
        cycle();
        check("nop_back",  n_out_data, 32'hDEAD_BEEF);
        check("nop_valid", 32'(n_out_valid), 32'h0);

        // asynchronous reset mid-cycle while in TWO
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hD1;
        cycle();
        a_in_data = 32'hD2;
        cycle();
        a_in_valid = 0;
        check("mr_setup_occ", 32'(a_occ), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid",    32'(a_out_valid), 32'h0);
        check("mr_nop",      a_out_data, 32'h0);
        check("mr_occ",      32'(a_occ), 32'h0);
        check("mr_ready_lo", 32'(a_in_ready), 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("mr_rel_ready", 32'(a_in_ready), 32'h1);
        cycle();
        check("mr_post_ready", 32'(a_in_ready), 32'h1);
        check("mr_post_valid", 32'(a_out_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/trans_stage.md
Name: trans_stage

Overview:
- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed-field stage registers.
- Carries an opaque payload bus of configurable width between two pipeline stages.
- Uses a valid/ready handshake instead of a global stall vector. An optional 2-entry skid buffer breaks the combinational ready path. Adds synchronous flush and a bubble (NOP) value on the output.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. Each stage packs its fields into the payload.

Parameters:
- DATA_WIDTH, 32: payload width in bits; legal range 1 and up.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- NOP_VALUE, {DATA_WIDTH{1'b0}}: value driven on out_data whenever out_valid=0.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- flush, input, 1: synchronous kill of all held entries (branch/exception redirect).
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: stage can accept this cycle.
- in_data, input, DATA_WIDTH: upstream payload.
- out_valid, output, 1: payload presented downstream.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, DATA_WIDTH: payload to the downstream stage; NOP_VALUE when out_valid=0.
- occupancy, output, 2: entries held (0..2; max 1 when SKID=0).

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. Both are evaluated at the rising edge.
- Reset (asynchronous): state=EMPTY, out_valid=0, out_data=NOP_VALUE, occupancy=0. in_ready=1 after reset deasserts. For SKID=1, in_ready is 0 while reset is asserted.
- Reset mid-transfer: any held payload is lost; no partial outputs.
- State machine, SKID=1 (main register M, skid register S):
  - EMPTY: out_valid=0, in_ready=1. Input transfer → M=in_data, go to ONE.
  - ONE: out_valid=1, out_data=M, in_ready=1.
    - Input and output transfer together → M=in_data, stay ONE.
    - Input only → S=in_data, go to TWO.
    - Output only → go to EMPTY.
  - TWO: out_valid=1, out_data=M, in_ready=0 (registered).
    - Output transfer → M=S, go to ONE.
- State machine, SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - EMPTY/ONE only; the same transitions as above apply, minus TWO.
- Latency and ordering:
  - Input to out_valid: 1 cycle.
  - Full throughput: 1 transfer per cycle when out_ready is held 1.
  - Strict FIFO order; no payload is ever dropped or duplicated except by flush.
- Flush:
  - At the edge, state goes to EMPTY, out_valid=0, out_data=NOP_VALUE.
  - An input offered in the same cycle is discarded.
  - in_ready is forced to 0 during a flush cycle, so upstream sees no transfer.
  - Flush overrides simultaneous input and output transfers. An output transfer in the flush cycle is still counted as consumed by downstream.
- Bubble: whenever out_valid=0, out_data=NOP_VALUE. Downstream decode therefore sees a NOP without checking valid.
- occupancy: EMPTY=0, ONE=1, TWO=2; updated at the same edge as the state.
- Width rules: payload is passed through bit-exact; no arithmetic.
- Error handling: in_valid dropping without a transfer is legal (no protocol assertion inside the block).

Decomposition:
- Shared package (defines): state encodings STAGE_EMPTY/ONE/TWO (2-bit); field offsets and widths for the per-stage payload packing (instruction, operator, category, operands, write enable/address/data); OP_NOP-based NOP_VALUE constants per stage.
- One sub-module is natural: trans_stage_skid (2-entry buffer datapath plus state). It is selected by a generate on SKID.
- Top-level wrappers (trans_if_id, trans_id_ex, …) are thin pack/unpack shells around trans_stage.

Test Plan:
- Reset: assert reset asynchronously mid-cycle while in state TWO → out_valid=0, out_data=NOP_VALUE, occupancy=0 immediately, without waiting for a clock edge. in_ready=1 on the first cycle after release.
- Streaming (SKID=1, DATA_WIDTH=32): out_ready=1, send 0x11,0x22,0x33 on consecutive cycles → out_data shows 0x11,0x22,0x33 on cycles 1,2,3. occupancy stays 1; in_ready stays 1.
- Backpressure/skid: out_ready=0, send 0xA1 then 0xA2 → occupancy=2, in_ready=0, out_data=0xA1. Raise out_ready for 2 cycles → 0xA1 then 0xA2 delivered, then EMPTY with out_data=NOP_VALUE.
- Flush collision: in TWO (0xB1,0xB2) with in_valid=1 (0xB3) and flush=1 → next cycle EMPTY, out_valid=0, out_data=NOP_VALUE. 0xB3 never appears; in_ready was 0 that cycle.
- SKID=0 combinational ready: hold out_valid=1 with out_ready toggling 0/1 → in_ready follows out_ready in the same cycle. Simultaneous input and output transfer replaces M with no bubble.
- NOP_VALUE override: instantiate with NOP_VALUE=0xDEADBEEF, idle after reset → out_data=0xDEADBEEF while out_valid=0.
